// File: rtl/seg_display_mux_if.sv
// Bundle of display data/control inputs and display pin outputs for seg_display_mux.
// The master side drives digit data and masks. The slave side (the mux) drives the pins.
interface seg_display_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 3
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [BRIGHT_W-1:0]     brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    blink_phase;

  modport master (
    output digits_in, dp_in, blank_mask, blink_mask, brightness,
    input  seg, dp, an, blink_phase
  );

  modport slave (
    input  digits_in, dp_in, blank_mask, blink_mask, brightness,
    output seg, dp, an, blink_phase
  );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Provides a hex decoder, blank, blink, decimal-point and PWM brightness control per digit.
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 500000,
  parameter int BLINK_DIV   = 25000000,
  parameter int BRIGHT_W    = 3
) (
  input logic clk,
  input logic rst,
  seg_display_mux_if.slave bus
);

  localparam int CW  = $clog2(REFRESH_DIV);
  localparam int BLW = $clog2(BLINK_DIV);
  localparam int SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OW  = BRIGHT_W + CW + 1;

  localparam logic [CW-1:0]  CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_DIV - 1);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [OW-1:0]  DIV_W      = OW'(REFRESH_DIV);

  logic [CW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [BLW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [OW-1:0]         on_q, on_d;
  logic                  vis_q, vis_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  slot_start;
  logic                  blink_wrap;
  logic [SW-1:0]         slot_next;
  logic [3:0]            nib_k;
  logic                  dp_k, blank_k, blink_k, vis_new;
  logic [OW-1:0]         on_prod, on_new;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_start    = (refresh_cnt_q == CNT_LAST);
    refresh_cnt_d = slot_start ? '0 : refresh_cnt_q + CW'(1);

    blink_wrap    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;

    slot_next = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);

    nib_k   = 4'h0;
    dp_k    = 1'b0;
    blank_k = 1'b0;
    blink_k = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_next == SW'(i)) begin
        nib_k   = bus.digits_in[4*i +: 4];
        dp_k    = bus.dp_in[i];
        blank_k = bus.blank_mask[i];
        blink_k = bus.blink_mask[i];
      end
    end

    // blink_phase_q is the pre-toggle value when a blink toggle coincides with a slot start
    vis_new = !blank_k && !(blink_k && !blink_phase_q);

    on_prod = ({{(OW-BRIGHT_W){1'b0}}, bus.brightness} + OW'(1)) * DIV_W;
    on_new  = on_prod >> BRIGHT_W;
    if (on_new == '0) on_new = OW'(1);

    slot_d = slot_q;
    on_d   = on_q;
    vis_d  = vis_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    if (slot_start) begin
      slot_d = slot_next;
      on_d   = on_new;
      vis_d  = vis_new;
      seg_d  = vis_new ? hex_decode(nib_k) : 7'h7F;
      dp_d   = vis_new ? !dp_k : 1'b1;
    end

    // Anode is keyed off the upcoming count: the cycle after each slot start stays dark to avoid ghosting
    an_d = '1;
    if (!slot_start && vis_q && (refresh_cnt_d != '0) &&
        ({{(OW-CW){1'b0}}, refresh_cnt_d} < on_q)) begin
      an_d = ~(NUM_DIGITS'(1) << slot_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      slot_q        <= SLOT_LAST;
      on_q          <= '0;
      vis_q         <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      slot_q        <= slot_d;
      on_q          <= on_d;
      vis_q         <= vis_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.blink_phase = blink_phase_q;

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.
- Successor to the fixed 4-digit driver: generalises digit count and refresh rate.
- Adds an internal blink generator, per-digit blank, per-digit blink and per-digit decimal-point control, and PWM brightness.
- Sits between the counter/BCD logic and the board display pins; the hex decoder is built in.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (legal range 1..8).
- REFRESH_DIV, 500000, clk cycles per digit slot (>=2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
- BRIGHT_W, 3, brightness code width.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- digits_in, input, 4*NUM_DIGITS, hex nibble per digit; nibble i is digit i, and digit 0 is rightmost.
- dp_in, input, NUM_DIGITS, decimal point request per digit, 1 = lit.
- blank_mask, input, NUM_DIGITS, 1 = digit fully dark.
- blink_mask, input, NUM_DIGITS, 1 = digit follows blink phase.
- brightness, input, BRIGHT_W, 0 = dimmest, all-ones = full on-time.
- seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
- dp, output, 1, active-low decimal point.
- an, output, NUM_DIGITS, active-low anode enables.
- blink_phase, output, 1, current blink phase (1 = visible half), exported for LEDs.

Behaviour:
- Reset (async, while rst=1):
  - an = all 1s, seg = 7'h7F, dp = 1.
  - refresh_cnt = 0, blink_cnt = 0, blink_phase = 1.
  - slot = NUM_DIGITS-1, so digit 0 is the first one shown after reset.
- Refresh counter:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - "Slot start" is the clock edge at which refresh_cnt==REFRESH_DIV-1.
  - On that edge, slot advances (wraps NUM_DIGITS-1 -> 0).
  - With NUM_DIGITS=1, slot stays 0.
- Slot-start capture, on the same edge, for the new slot k:
  - Register digits_in nibble k, dp_in[k], blank_mask[k], blink_mask[k], brightness and the current blink_phase.
  - Inputs are don't-care between slot starts.
  - Any input change is therefore visible within one slot (<= REFRESH_DIV cycles).
- Visibility:
  - vis = !blank_k && !(blink_k && !phase_captured).
- Outputs, all registered:
  - seg = decode(nibble) if vis, else 7'h7F.
  - dp = !dp_k if vis, else 1.
- PWM on-time:
  - ON = max(1, ((brightness+1)*REFRESH_DIV) >> BRIGHT_W) cycles.
  - Compute ON once per slot start; width is BRIGHT_W+clog2(REFRESH_DIV)+1 bits, with no overflow.
  - an[k] = 0 for the first ON cycles of the slot (refresh_cnt 0..ON-1 after the slot-start edge) when vis=1; otherwise an[k] = 1.
  - All other an bits = 1 at all times.
  - Never more than one an bit is low.
- Blank-before-switch:
  - On the slot-start edge, an goes all-1s for exactly one cycle before the new digit's anode asserts. This eliminates ghosting.
  - Net effect: the new digit's anode is low on the cycles where refresh_cnt is 1..ON-1.
- Blink generator:
  - blink_cnt counts 0..BLINK_DIV-1.
  - blink_phase toggles on the edge where blink_cnt==BLINK_DIV-1.
  - It is free-running and independent of slot timing.
  - If a toggle and a slot start occur on the same edge, the slot captures the pre-toggle phase.
- Decoder (hex 0..F, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Mid-operation reset: all outputs return immediately to their reset values. The first visible digit after release is digit 0, with its slot start REFRESH_DIV cycles after release.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLINK_DIV=64, BRIGHT_W=2):
- Reset and scan:
  - Stimulus: digits_in=16'h3210, masks 0, brightness=3, release rst.
  - Required: an stays 4'b1111 for 8 cycles, then one blank cycle.
  - Then an=4'b1110 with seg=1000000 for 7 cycles, then an=4'b1101 with seg=1111001, and so on.
  - After digit 3, the scan wraps to an=4'b1110.
- Brightness:
  - Stimulus: brightness=1.
  - Required: ON=4, so each an bit is low for 3 cycles per 8-cycle slot.
  - Stimulus: brightness=0.
  - Required: ON=2, so each an bit is low for 1 cycle.
- Blank and dp:
  - Stimulus: blank_mask=4'b0100, dp_in=4'b0001.
  - Required: the digit-2 slot keeps an=1111, seg=7F, dp=1; the digit-0 slot drives dp=0.
- Blink:
  - Stimulus: blink_mask=4'b1100, observed over 256 cycles.
  - Required: digits 2 and 3 are dark in slots captured while blink_phase=0 and lit otherwise; digits 0 and 1 are always lit; blink_phase toggles every 64 cycles.
- Hex decode:
  - Stimulus: digits_in=16'hFEDC.
  - Required: seg = 1000110, 0100001, 0000110, 0001110 for digits 0..3 respectively.
- Async reset mid-slot:
  - Stimulus: assert rst at refresh_cnt=3 of the digit-1 slot, for 2 cycles.
  - Required: an=1111 and seg=7F in the same cycle; after release, digit 0 is shown first, after the 8-cycle delay.
